// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin arbiter with burst lock that shares the data RAM's
//               single read/write port between the CPU (m0) and DMA (m1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
  parameter int WIDTH          = 16,
  parameter int REGISTER_COUNT = 1024,
  localparam int AW            = $clog2(REGISTER_COUNT)
) (
  input  logic             cpu_clk,
  input  logic             rst_n,

  input  logic             m0_req,
  input  logic             m0_we,
  input  logic             m0_lock,
  input  logic [AW-1:0]    m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,

  input  logic             m1_req,
  input  logic             m1_we,
  input  logic             m1_lock,
  input  logic [AW-1:0]    m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,

  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   last_grant_next;

  // Grant and next-state; an owner that drops its request falls back to
  // ordinary round-robin in the same cycle.
  always_comb begin
    m0_gnt          = 1'b0;
    m1_gnt          = 1'b0;
    state_next      = ST_IDLE;
    last_grant_next = last_grant;

    if (rst_n) begin
      if (state == ST_OWN0 && m0_req) begin
        m0_gnt = 1'b1;
      end else if (state == ST_OWN1 && m1_req) begin
        m1_gnt = 1'b1;
      end else if (m0_req && m1_req) begin
        m0_gnt = last_grant;
        m1_gnt = ~last_grant;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end

    if (m0_gnt) begin
      last_grant_next = 1'b0;
      state_next      = m0_lock ? ST_OWN0 : ST_IDLE;
    end else if (m1_gnt) begin
      last_grant_next = 1'b1;
      state_next      = m1_lock ? ST_OWN1 : ST_IDLE;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (m0_gnt) begin
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_we    = m0_we;
    end else if (m1_gnt) begin
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_we    = m1_we;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      m0_rvalid  <= m0_gnt & ~m0_we;
      m1_rvalid  <= m1_gnt & ~m1_we;
    end
  end

  // RAM read data is already registered; both ports see it, rvalid qualifies.
  assign m0_rdata = ram_rdata;
  assign m1_rdata = ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed self-checking bench with a RAM model and a
//               transaction-level reference model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0]    m0_addr, m1_addr;
  logic [WIDTH-1:0] m0_wdata, m1_wdata;
  logic             m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [WIDTH-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;
  logic             ram_we;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.WIDTH(WIDTH), .REGISTER_COUNT(DEPTH)) dut (
    .cpu_clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  // Synchronous RAM with one-cycle registered read (read-before-write).
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 16'h0100 + 16'(i);
      ref_mem[i] = 16'h0100 + 16'(i);
    end
  end
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: owner (-1 none, 0, 1), last winner, pending read results.
  int               owner = -1;
  int               last  = 1;
  int               e_g0 = 0, e_g1 = 0;
  int               e_rv0 = 0, e_rv1 = 0;
  logic [WIDTH-1:0] e_rd0, e_rd1;
  logic             c_we0, c_we1;
  logic [AW-1:0]    c_a0, c_a1;
  logic [WIDTH-1:0] c_d0, c_d1;

  always @(negedge clk) begin
    int win;
    win = -1;
    if (rst_n) begin
      if (owner == 0 && m0_req)      win = 0;
      else if (owner == 1 && m1_req) win = 1;
      else if (m0_req && m1_req)     win = (last == 1) ? 0 : 1;
      else if (m0_req)               win = 0;
      else if (m1_req)               win = 1;
    end
    e_g0 = (win == 0) ? 1 : 0;
    e_g1 = (win == 1) ? 1 : 0;
    c_we0 = m0_we; c_we1 = m1_we; c_a0 = m0_addr; c_a1 = m1_addr;
    c_d0 = m0_wdata; c_d1 = m1_wdata;

    chk("m0_gnt", 32'(m0_gnt), 32'(e_g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e_g1));
    chk("ram_we", 32'(ram_we), (win == 0) ? 32'(m0_we) : (win == 1) ? 32'(m1_we) : 32'd0);
    chk("ram_addr", 32'(ram_addr), (win == 0) ? 32'(m0_addr) : (win == 1) ? 32'(m1_addr) : 32'd0);
    chk("ram_wdata", 32'(ram_wdata), (win == 0) ? 32'(m0_wdata) : (win == 1) ? 32'(m1_wdata) : 32'd0);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv1));
    if (e_rv0 != 0) chk("m0_rdata", 32'(m0_rdata), 32'(e_rd0));
    if (e_rv1 != 0) chk("m1_rdata", 32'(m1_rdata), 32'(e_rd1));
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      owner = -1; last = 1; e_rv0 = 0; e_rv1 = 0;
    end else begin
      e_rv0 = (e_g0 != 0 && !c_we0) ? 1 : 0;
      e_rv1 = (e_g1 != 0 && !c_we1) ? 1 : 0;
      e_rd0 = ref_mem[c_a0];
      e_rd1 = ref_mem[c_a1];
      owner = -1;
      if (e_g0 != 0) begin
        last = 0;
        if (m0_lock) owner = 0;
        if (c_we0) ref_mem[c_a0] = c_d0;
      end else if (e_g1 != 0) begin
        last = 1;
        if (m1_lock) owner = 1;
        if (c_we1) ref_mem[c_a1] = c_d1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic to_neg();
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1; m0_we = 1; m0_lock = 0; m0_addr = 5; m0_wdata = 16'h5555;
    m1_req = 1; m1_we = 1; m1_lock = 0; m1_addr = 6; m1_wdata = 16'h6666;

    // Reset held with both requesting
    for (int i = 0; i < 2; i++) begin
      to_neg();
      chk("rst m0_gnt", 32'(m0_gnt), 0);
      chk("rst m1_gnt", 32'(m1_gnt), 0);
      chk("rst ram_we", 32'(ram_we), 0);
      chk("rst rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
      tick();
    end

    // Tie: alternating reads of 5 and 6
    rst_n = 1; m0_we = 0; m1_we = 0;
    to_neg(); chk("tie1 m0_gnt", 32'(m0_gnt), 1); chk("tie1 m1_gnt", 32'(m1_gnt), 0);
    tick();
    to_neg(); chk("tie2 m1_gnt", 32'(m1_gnt), 1);
    chk("tie2 m0_rvalid", 32'(m0_rvalid), 1); chk("tie2 m0_rdata", 32'(m0_rdata), 32'h0105);
    tick();
    to_neg(); chk("tie3 m0_gnt", 32'(m0_gnt), 1);
    chk("tie3 m1_rvalid", 32'(m1_rvalid), 1); chk("tie3 m1_rdata", 32'(m1_rdata), 32'h0106);
    tick();
    m0_req = 0; m1_req = 0;
    to_neg(); chk("tie4 m0_rvalid", 32'(m0_rvalid), 1); chk("tie4 m0_rdata", 32'(m0_rdata), 32'h0105);
    tick();

    // Locked burst of 4 writes by m1, m0 waiting
    m0_req = 1; m0_we = 0; m0_addr = 7; m0_lock = 0;
    m1_req = 1; m1_we = 1; m1_wdata = 16'h00AA;
    for (int i = 0; i < 4; i++) begin
      m1_addr = AW'(i); m1_lock = (i != 3);
      to_neg();
      chk("burst m1_gnt", 32'(m1_gnt), 1);
      chk("burst m0_gnt", 32'(m0_gnt), 0);
      chk("burst ram_addr", 32'(ram_addr), 32'(i));
      tick();
    end
    m1_req = 0; m1_lock = 0; m0_lock = 1;
    to_neg(); chk("burst5 m0_gnt", 32'(m0_gnt), 1);
    tick();

    // Lock drop: m0 owns but stops requesting
    m0_req = 0; m0_lock = 0;
    m1_req = 1; m1_we = 0; m1_addr = 2;
    to_neg(); chk("drop m1_gnt", 32'(m1_gnt), 1);
    chk("drop m0_rdata", 32'(m0_rdata), 32'h0107);
    tick();
    m1_req = 0;
    to_neg(); chk("drop m1_rvalid", 32'(m1_rvalid), 1); chk("drop m1_rdata", 32'(m1_rdata), 32'h00AA);
    tick();

    // Write by m0 then read back by m1
    m0_req = 1; m0_we = 1; m0_addr = 10; m0_wdata = 16'h1234;
    to_neg(); chk("wr m0_gnt", 32'(m0_gnt), 1);
    tick();
    m0_req = 0; m0_we = 0;
    m1_req = 1; m1_we = 0; m1_addr = 10;
    to_neg(); chk("rd m1_gnt", 32'(m1_gnt), 1); chk("wr m0_rvalid", 32'(m0_rvalid), 0);
    tick();
    m1_req = 0;
    to_neg(); chk("rd m1_rvalid", 32'(m1_rvalid), 1); chk("rd m1_rdata", 32'(m1_rdata), 32'h1234);
    chk("rd m0_rvalid", 32'(m0_rvalid), 0);
    tick();

    // Reset arriving at the edge that ends a granted, locked read
    m0_req = 1; m0_we = 0; m0_addr = 5; m0_lock = 1;
    to_neg(); chk("rr m0_gnt", 32'(m0_gnt), 1);
    #1 rst_n = 0;
    tick();
    chk("rr m0_rvalid", 32'(m0_rvalid), 0);
    m0_lock = 0; m1_req = 1; m1_we = 0; m1_addr = 6;
    rst_n = 1;
    to_neg(); chk("rr tie m0_gnt", 32'(m0_gnt), 1); chk("rr tie m1_gnt", 32'(m1_gnt), 0);
    tick();
    m0_req = 0; m1_req = 0;
    to_neg();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
